// File: rtl/axis_pkg.sv
// Shared AXI-stream sample types for the spectral front-end blocks.
package axis_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } sample_t_int;

endpackage

// File: rtl/sample_framer.sv
// Gathers single-sample AXI-stream input into BUS_NUM-lane beats, framed
// into FFT_SIZE-sample frames with tlast on the final beat of each frame.
module sample_framer
    import axis_pkg::*;
#(
    parameter int FFT_SIZE = 8192,
    parameter int BUS_NUM  = 2,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_tvalid,
    output logic                        in_tready,
    input  sample_t_int                 in_tdata,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic                        out_tlast,
    output sample_t_int [BUS_NUM-1:0]   out_tdata,
    output logic                        busy,
    output logic [CNT_W-1:0]            frame_cnt
);

    localparam int BEATS  = FFT_SIZE / BUS_NUM;
    localparam int LANE_W = $clog2(BUS_NUM);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BUS_NUM - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state;
    logic [LANE_W-1:0]          lane_cnt;
    logic [BEAT_W-1:0]          beat_cnt;
    sample_t_int [BUS_NUM-2:0]  gather;
    logic                       last_lane;
    logic                       last_beat;
    logic                       in_hs;

    // Only the group-completing sample needs the output register free; the
    // other lanes land in the gather register and can always be taken.
    assign last_lane = (lane_cnt == LAST_LANE);
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign in_tready = (state == RUN) && (!last_lane || !out_tvalid || out_tready);
    assign in_hs     = in_tvalid && in_tready;
    assign busy      = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lane_cnt   <= '0;
            beat_cnt   <= '0;
            gather     <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (out_tvalid && out_tready) begin
                out_tvalid <= 1'b0;
                if (out_tlast) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end

            // A load in the same cycle as a drain overrides the clear above.
            if (in_hs) begin
                if (last_lane) begin
                    for (int k = 0; k < BUS_NUM - 1; k++) begin
                        out_tdata[k] <= gather[k];
                    end
                    out_tdata[BUS_NUM-1] <= in_tdata;
                    out_tvalid           <= 1'b1;
                    out_tlast            <= last_beat;
                    lane_cnt             <= '0;
                    beat_cnt             <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
                end else begin
                    for (int k = 0; k < BUS_NUM - 1; k++) begin
                        if (lane_cnt == LANE_W'(k)) begin
                            gather[k] <= in_tdata;
                        end
                    end
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end
            end

            // Dropping en only takes effect at a frame boundary.
            case (state)
                IDLE: if (en) state <= RUN;
                RUN:  if (in_hs && last_lane && last_beat && !en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_framer.sv
// Randomized bench for sample_framer, checked against a queue-based frame model.
module tb_sample_framer;
    import axis_pkg::*;

    localparam int FFT_SIZE = 8;
    localparam int BUS_NUM  = 2;
    localparam int CNT_W    = 2;

    typedef sample_t_int [BUS_NUM-1:0] beat_t;

    logic                      clk;
    logic                      rst;
    logic                      en;
    logic                      in_tvalid;
    logic                      in_tready;
    sample_t_int               in_tdata;
    logic                      out_tvalid;
    logic                      out_tready;
    logic                      out_tlast;
    beat_t                     out_tdata;
    logic                      busy;
    logic [CNT_W-1:0]          frame_cnt;

    int assertCount = 0;
    int failCount   = 0;

    bit               model_valid = 0;
    bit               m_busy;
    int               m_acc;
    beat_t            m_grp;
    beat_t            m_beats[$];
    bit               m_lasts[$];
    logic [CNT_W-1:0] m_frames;
    bit               dut_hs;
    int               out_beats = 0;
    int               tlast_cnt = 0;

    sample_framer #(
        .FFT_SIZE (FFT_SIZE),
        .BUS_NUM  (BUS_NUM),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .out_tdata  (out_tdata),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v, input int re, input bit rdy);
        rst          = r;
        en           = e;
        in_tvalid    = v;
        in_tdata.re  = 16'(re);
        in_tdata.im  = ~16'(re);
        out_tready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input bit e);
        repeat (n) applyStimulus(1'b0, e, 1'b0, 0, 1'b1);
    endtask

    // Offers samples first..first+n-1 in order; en stays high until en_keep samples are taken.
    task automatic sendSamples(input int first, input int n, input int vpct, input int rpct,
                               input int en_keep, input int hold_from, input int hold_len);
        int idx = 0;
        int cyc = 0;
        bit v, r, e;
        while (idx < n && cyc < 400) begin
            v = ($urandom_range(99) < vpct);
            r = ($urandom_range(99) < rpct) && !(cyc >= hold_from && cyc < hold_from + hold_len);
            e = (idx < en_keep);
            applyStimulus(1'b0, e, v, first + idx, r);
            if (dut_hs) idx++;
            cyc++;
        end
        checkOutput("send_budget", 128'(idx), 128'(n));
    endtask

    // Reference model: samples accumulate into groups, completed groups queue as beats.
    always @(negedge clk) begin
        bit exp_ready;
        bit in_hs_m;
        bit out_hs_m;
        exp_ready = m_busy && (((m_acc % BUS_NUM) != BUS_NUM - 1) || (m_beats.size() == 0) || out_tready);
        if (model_valid) begin
            checkOutput("in_tready", 128'(in_tready), 128'(exp_ready));
            checkOutput("out_tvalid", 128'(out_tvalid), 128'(m_beats.size() != 0));
            checkOutput("busy", 128'(busy), 128'(m_busy));
            checkOutput("frame_cnt", 128'(frame_cnt), 128'(m_frames));
            if (m_beats.size() != 0) begin
                checkOutput("out_tdata", 128'(out_tdata), 128'(m_beats[0]));
                checkOutput("out_tlast", 128'(out_tlast), 128'(m_lasts[0]));
            end
        end
        dut_hs = in_tvalid && in_tready;
        if (out_tvalid && out_tready) begin
            out_beats++;
            if (out_tlast) tlast_cnt++;
        end
        if (rst) begin
            model_valid = 1;
            m_busy      = 0;
            m_acc       = 0;
            m_grp       = '0;
            m_frames    = '0;
            m_beats.delete();
            m_lasts.delete();
        end else begin
            in_hs_m  = in_tvalid && exp_ready;
            out_hs_m = (m_beats.size() != 0) && out_tready;
            if (out_hs_m) begin
                if (m_lasts[0]) m_frames = m_frames + 1'b1;
                void'(m_beats.pop_front());
                void'(m_lasts.pop_front());
            end
            if (in_hs_m) begin
                m_grp[m_acc % BUS_NUM] = in_tdata;
                m_acc++;
                if (m_acc % BUS_NUM == 0) begin
                    m_beats.push_back(m_grp);
                    m_lasts.push_back(m_acc == FFT_SIZE);
                end
                if (m_acc == FFT_SIZE) begin
                    m_acc = 0;
                    if (!en) m_busy = 0;
                end
            end else if (!m_busy && en) begin
                m_busy = 1;
            end
        end
    end

    initial begin
        int base_beats;
        int base_lasts;
        rst        = 1'b1;
        en         = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("reset_tdata", 128'(out_tdata), 128'(0));
        checkOutput("reset_tlast", 128'(out_tlast), 128'(0));
        checkOutput("reset_tvalid", 128'(out_tvalid), 128'(0));

        $display("[TB] continuous frame, ready held high");
        sendSamples(1, 8, 100, 100, 1000, 1000, 0);
        idleCycles(2, 1'b1);
        checkOutput("frame_cnt_one", 128'(frame_cnt), 128'(1));

        $display("[TB] output stall after first beat");
        sendSamples(1, 8, 100, 100, 1000, 2, 5);
        idleCycles(2, 1'b1);

        $display("[TB] en dropped after third sample");
        sendSamples(1, 8, 100, 100, 3, 1000, 0);
        idleCycles(3, 1'b0);
        checkOutput("busy_after_drop", 128'(busy), 128'(0));

        $display("[TB] reset mid-frame then restart");
        sendSamples(1, 5, 100, 100, 1000, 1000, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("midreset_tvalid", 128'(out_tvalid), 128'(0));
        checkOutput("midreset_frames", 128'(frame_cnt), 128'(0));
        sendSamples(11, 8, 100, 100, 1000, 1000, 0);
        idleCycles(3, 1'b1);

        $display("[TB] random handshakes over three frames");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
        base_beats = out_beats;
        base_lasts = tlast_cnt;
        sendSamples(21, 24, 60, 60, 1000, 1000, 0);
        idleCycles(4, 1'b1);
        checkOutput("beats_3frames", 128'(out_beats - base_beats), 128'(12));
        checkOutput("tlast_3frames", 128'(tlast_cnt - base_lasts), 128'(3));
        checkOutput("frame_cnt_3", 128'(frame_cnt), 128'(3));

        $display("[TB] frame counter wrap");
        sendSamples(45, 16, 70, 70, 1000, 1000, 0);
        idleCycles(4, 1'b1);
        checkOutput("frame_cnt_wrap", 128'(frame_cnt), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
